sat_accumulate_lanes: RTL and testbench

Multi-lane, multi-beat saturating accumulator. Sums a stream of N-lane signed vectors over a configurable number of beats and emits one N-lane result per block. Each lane clamps to the signed P-bit range on overflow and raises a per-lane overflow flag. Sits after the element-wise saturating add stage in the datapath, where reductions across time (dot-product partials, bias accumulation) are needed. Valid/ready handshakes on both sides.

---
 rtl/sat_accumulate_lanes.sv | 119 +++++++++++
 tb/tb_sat_accumulate_lanes.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sat_accumulate_lanes.sv
// Multi-lane, multi-beat saturating accumulator: sums N-lane signed beats over a
// configurable block length and emits one clamped (or wrapped) result per block.
module sat_accumulate_lanes #(
  parameter int P     = 32,
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   cfg_len,
  input  logic               cfg_sat_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*P-1:0]     in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*P-1:0]     out_data,
  output logic [N-1:0]       out_ovf
);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t                r_state;
  state_t                w_next;
  logic signed [P-1:0]   r_acc [N];
  logic [P:0]            w_res [N];
  logic [N-1:0]          r_ovf;
  logic [N-1:0]          w_lane_ovf;
  logic [N-1:0]          w_ovf_next;
  logic [N-1:0]          r_out_ovf;
  logic [N*P-1:0]        w_sum_flat;
  logic [N*P-1:0]        r_out_data;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_len;
  logic [CNT_W-1:0]      w_len;
  logic                  r_sat_en;
  logic                  w_sat;
  logic                  w_first;
  logic                  w_last;
  logic                  w_accept;

  // Returns {overflow, result}; result is clamped when sat is set, wrapped otherwise.
  function automatic logic [P:0] sat_add(input logic signed [P-1:0] a,
                                         input logic signed [P-1:0] b,
                                         input logic sat);
    logic signed [P-1:0] s;
    logic                pos;
    logic                neg;
    s   = a + b;
    pos = !a[P-1] && !b[P-1] &&  s[P-1];
    neg =  a[P-1] &&  b[P-1] && !s[P-1];
    if (sat && pos)      s = {1'b0, {(P-1){1'b1}}};
    else if (sat && neg) s = {1'b1, {(P-1){1'b0}}};
    return {pos | neg, s};
  endfunction

  assign in_ready  = (r_state == ST_ACC) && !rst;
  assign out_valid = (r_state == ST_HOLD);
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign w_accept  = in_ready && in_valid;

  // First beat of a block uses live config and ignores the stale accumulator.
  always_comb begin
    w_first = (r_cnt == '0);
    w_len   = w_first ? ((cfg_len == '0) ? CNT_W'(1) : cfg_len) : r_len;
    w_sat   = w_first ? cfg_sat_en : r_sat_en;
    w_last  = (r_cnt == w_len - CNT_W'(1));
    w_sum_flat = '0;
    w_lane_ovf = '0;
    for (int i = 0; i < N; i++) begin
      w_res[i] = sat_add(w_first ? '0 : r_acc[i], in_data[i*P +: P], w_sat);
      w_sum_flat[i*P +: P] = w_res[i][P-1:0];
      w_lane_ovf[i] = w_res[i][P];
    end
    w_ovf_next = w_first ? w_lane_ovf : (r_ovf | w_lane_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ACC;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ACC:  if (w_accept && w_last) w_next = ST_HOLD;
      ST_HOLD: if (out_ready)          w_next = ST_ACC;
      default: w_next = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_len      <= '0;
      r_sat_en   <= 1'b0;
      r_ovf      <= '0;
      r_out_data <= '0;
      r_out_ovf  <= '0;
      for (int i = 0; i < N; i++) r_acc[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < N; i++) r_acc[i] <= w_res[i][P-1:0];
      r_ovf <= w_ovf_next;
      if (w_first) begin
        r_len    <= w_len;
        r_sat_en <= w_sat;
      end
      if (w_last) begin
        r_cnt      <= '0;
        r_out_data <= w_sum_flat;
        r_out_ovf  <= w_ovf_next;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sat_accumulate_lanes.sv
// Directed plus randomized bench for sat_accumulate_lanes (P=8, N=2, CNT_W=4)
// against an integer-arithmetic reference model.
module tb_sat_accumulate_lanes;

  localparam int P = 8;
  localparam int N = 2;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] cfg_len;
  logic             cfg_sat_en;
  logic             in_valid;
  logic             in_ready;
  logic [N*P-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N*P-1:0]   out_data;
  logic [N-1:0]     out_ovf;

  int tests = 0;
  int fails = 0;
  int v0 [16];
  int v1 [16];

  sat_accumulate_lanes #(.P(P), .N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_sat_en(cfg_sat_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum, then clamp or wrap into signed 8-bit range.
  function automatic int model_step(input int acc, input int x, input bit sat, output bit ovf);
    int s;
    s = acc + x;
    ovf = (s > 127) || (s < -128);
    if (!ovf) return s;
    if (sat)  return (s > 127) ? 127 : -128;
    return ((s + 128) & 255) - 128;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one block from v0/v1, holds the result for hold_cyc cycles, then drains it.
  task automatic run_block(input int cfg, input bit sat, input int hold_cyc, input string tag);
    int n, a0, a1;
    bit f, o0, o1;
    logic [15:0] exp_d;
    logic [15:0] held_d;
    logic [1:0]  held_o;
    n = (cfg == 0) ? 1 : cfg;
    a0 = 0; a1 = 0; o0 = 0; o1 = 0;
    for (int k = 0; k < n; k++) begin
      a0 = model_step(a0, v0[k], sat, f); o0 |= f;
      a1 = model_step(a1, v1[k], sat, f); o1 |= f;
    end
    exp_d = {a1[7:0], a0[7:0]};
    out_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        cfg_len = CNT_W'(cfg);
        cfg_sat_en = sat;
      end else begin
        cfg_len = 4'd1;
        cfg_sat_en = ~sat;
      end
      in_valid = 1'b1;
      in_data = {v1[k][7:0], v0[k][7:0]};
      if (k == 0 || k == n - 1) chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_busy_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    in_data = 16'hA5A5;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'(exp_d));
    chk({tag, "_out_ovf"}, 32'(out_ovf), 32'({o1, o0}));
    held_d = out_data;
    held_o = out_ovf;
    for (int c = 0; c < hold_cyc; c++) begin
      tick();
      chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_stall_data"}, 32'({held_o, held_d}), 32'({out_ovf, out_data}));
      chk({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cfg_len = '0; cfg_sat_en = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready_gated", 32'(in_ready), 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);

    v0[0] = 10; v0[1] = 20; v0[2] = 30;
    v1[0] = -5; v1[1] = -5; v1[2] = -5;
    run_block(3, 1'b1, 0, "basic");

    v0[0] = 100;  v0[1] = 100;  v0[2] = -50;
    v1[0] = -100; v1[1] = -100; v1[2] = 0;
    run_block(3, 1'b1, 0, "sat_recover");
    chk("sat_recover_lane0", 32'(out_data[7:0]), 32'd77);
    run_block(3, 1'b0, 0, "wrap");

    v0[0] = 1; v0[1] = 2; v0[2] = 3;
    v1[0] = 4; v1[1] = 5; v1[2] = 6;
    run_block(3, 1'b1, 5, "backpressure");
    v0[0] = 7; v1[0] = -7;
    run_block(1, 1'b1, 0, "len1_after_bp");
    run_block(0, 1'b0, 0, "len0");

    // Reset in the middle of a block discards the partial sum.
    cfg_len = 4'd3; cfg_sat_en = 1'b1; in_valid = 1'b1;
    in_data = {8'd50, 8'd60};
    tick(); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready_gated", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_ovf", 32'(out_ovf), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    v0[0] = 1; v0[1] = 1; v1[0] = 1; v1[1] = 1;
    run_block(2, 1'b1, 0, "after_rst");

    for (int k = 0; k < 15; k++) begin
      v0[k] = int'($urandom_range(255)) - 128;
      v1[k] = int'($urandom_range(255)) - 128;
    end
    run_block(15, 1'b1, 0, "max_len_sat");
    run_block(15, 1'b0, 1, "max_len_wrap");

    for (int b = 0; b < 25; b++) begin
      int len;
      len = int'($urandom_range(6));
      for (int k = 0; k < 16; k++) begin
        v0[k] = int'($urandom_range(255)) - 128;
        v1[k] = int'($urandom_range(255)) - 128;
      end
      run_block(len, 1'($urandom_range(1)), int'($urandom_range(2)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
